// File: rtl/writeback_stage_p.sv
`default_nettype none
// ============================================================================
// Module   : writeback_stage_p
// Brief    : MEM/WB pipeline register with load formatting and result select.
//            Optional retire counter enabled by macro WB_RETIRE_COUNT_EN.
// Revision : 1.0
// ============================================================================
module writeback_stage_p #(
    parameter int XLEN     = 32,
    parameter int REG_AW   = 5,
    parameter int RETIRE_W = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                StallW,
    input  logic                FlushW,
    input  logic                ValidM,
    input  logic                RegWriteM,
    input  logic [1:0]          ResultSrcM,
    input  logic [2:0]          Funct3M,
    input  logic [REG_AW-1:0]   RdM,
    input  logic [XLEN-1:0]     ALUResultM,
    input  logic [XLEN-1:0]     ReadDataM,
    input  logic [XLEN-1:0]     PCPlus4M,
    input  logic [XLEN-1:0]     ImmExtM,
    output logic                ValidW,
    output logic                RegWriteW,
    output logic [REG_AW-1:0]   RdW,
    output logic [XLEN-1:0]     ResultW,
    output logic [RETIRE_W-1:0] RetireCount
);

    localparam int c_OFS_W = $clog2(XLEN / 8);

    logic              r_valid;
    logic              r_regWrite;
    logic [1:0]        r_resultSrc;
    logic [2:0]        r_funct3;
    logic [REG_AW-1:0] r_rd;
    logic [XLEN-1:0]   r_aluResult;
    logic [XLEN-1:0]   r_readData;
    logic [XLEN-1:0]   r_pcPlus4;
    logic [XLEN-1:0]   r_immExt;

    logic [c_OFS_W-1:0] w_ofs;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [31:0]        w_word;
    logic [XLEN-1:0]    w_loadData;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_regWrite  <= 1'b0;
            r_resultSrc <= 2'b00;
            r_funct3    <= 3'b000;
            r_rd        <= '0;
            r_aluResult <= '0;
            r_readData  <= '0;
            r_pcPlus4   <= '0;
            r_immExt    <= '0;
        end else if (FlushW) begin
            r_valid     <= 1'b0;
            r_regWrite  <= 1'b0;
            r_resultSrc <= 2'b00;
            r_funct3    <= 3'b000;
            r_rd        <= '0;
            r_aluResult <= '0;
            r_readData  <= '0;
            r_pcPlus4   <= '0;
            r_immExt    <= '0;
        end else if (!StallW) begin
            r_valid     <= ValidM;
            r_regWrite  <= RegWriteM;
            r_resultSrc <= ResultSrcM;
            r_funct3    <= Funct3M;
            r_rd        <= RdM;
            r_aluResult <= ALUResultM;
            r_readData  <= ReadDataM;
            r_pcPlus4   <= PCPlus4M;
            r_immExt    <= ImmExtM;
        end
    end

    // Offset bits below the access size are dropped, so misaligned loads read the aligned lane.
    assign w_ofs  = r_aluResult[c_OFS_W-1:0];
    assign w_byte = r_readData[{w_ofs, 3'b000} +: 8];
    assign w_half = r_readData[{w_ofs[c_OFS_W-1:1], 4'b0000} +: 16];

    generate
        if (XLEN == 64) begin : g_xlen64
            assign w_word = r_readData[{w_ofs[2], 5'b00000} +: 32];
        end else begin : g_xlen32
            assign w_word = r_readData[31:0];
        end
    endgenerate

    always_comb begin
        w_loadData = r_readData;
        case (r_funct3)
            3'b000:  w_loadData = XLEN'($signed(w_byte));
            3'b100:  w_loadData = XLEN'(w_byte);
            3'b001:  w_loadData = XLEN'($signed(w_half));
            3'b101:  w_loadData = XLEN'(w_half);
            3'b010:  w_loadData = XLEN'($signed(w_word));
            3'b110:  w_loadData = (XLEN == 64) ? XLEN'(w_word) : r_readData;
            default: w_loadData = r_readData;
        endcase
    end

    always_comb begin
        ResultW = r_aluResult;
        case (r_resultSrc)
            2'b00:   ResultW = r_aluResult;
            2'b01:   ResultW = w_loadData;
            2'b10:   ResultW = r_pcPlus4;
            default: ResultW = r_immExt;
        endcase
    end

    assign ValidW    = r_valid;
    assign RdW       = r_rd;
    assign RegWriteW = r_valid & r_regWrite & (r_rd != '0);

`ifdef WB_RETIRE_COUNT_EN
    logic [RETIRE_W-1:0] r_retireCount;

    // An instruction retires as it leaves WB; a same-cycle flush only kills the incoming one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retireCount <= '0;
        end else if (r_valid && !StallW) begin
            r_retireCount <= r_retireCount + 1'b1;
        end
    end

    assign RetireCount = r_retireCount;
`else
    assign RetireCount = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage_p.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_stage_p
// Brief    : Directed vector bench for writeback_stage_p (XLEN=32).
// Revision : 1.0
// ============================================================================
module tb_writeback_stage_p;

    logic        clk;
    logic        rst_n;
    logic        StallW;
    logic        FlushW;
    logic        ValidM;
    logic        RegWriteM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  Funct3M;
    logic [4:0]  RdM;
    logic [31:0] ALUResultM;
    logic [31:0] ReadDataM;
    logic [31:0] PCPlus4M;
    logic [31:0] ImmExtM;
    logic        ValidW;
    logic        RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;
    logic [63:0] RetireCount;

    int nCompared = 0;
    int nMismatched = 0;

    writeback_stage_p #(.XLEN(32), .REG_AW(5), .RETIRE_W(64)) dut (
        .clk(clk), .rst_n(rst_n), .StallW(StallW), .FlushW(FlushW),
        .ValidM(ValidM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
        .Funct3M(Funct3M), .RdM(RdM), .ALUResultM(ALUResultM),
        .ReadDataM(ReadDataM), .PCPlus4M(PCPlus4M), .ImmExtM(ImmExtM),
        .ValidW(ValidW), .RegWriteW(RegWriteW), .RdW(RdW),
        .ResultW(ResultW), .RetireCount(RetireCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        validM;
        logic        regWriteM;
        logic [1:0]  src;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] expRes;
        logic        expValid;
        logic        expWe;
        logic [4:0]  expRd;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] required);
        nCompared++;
        if (actual !== required) begin
            nMismatched++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, actual, required);
        end
    endtask

    task automatic checkW(input string name, input logic v, input logic we,
                          input logic [4:0] rd, input logic [31:0] res);
        check({name, ".ValidW"}, 64'(ValidW), 64'(v));
        check({name, ".RegWriteW"}, 64'(RegWriteW), 64'(we));
        check({name, ".RdW"}, 64'(RdW), 64'(rd));
        check({name, ".ResultW"}, 64'(ResultW), 64'(res));
    endtask

    task automatic setM(input logic v, input logic we, input logic [1:0] src,
                        input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] alu);
        ValidM = v; RegWriteM = we; ResultSrcM = src; Funct3M = f3; RdM = rd; ALUResultM = alu;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkRetire(input string name, input logic [63:0] expOn);
`ifdef WB_RETIRE_COUNT_EN
        check(name, RetireCount, expOn);
`else
        check(name, RetireCount, 64'd0);
`endif
    endtask

    initial begin
        // validM we src f3 rd alu rdata expRes expValid expWe expRd
        vecs[0]  = '{1'b1, 1'b1, 2'b01, 3'b000, 5'd1,  32'h1000, 32'h876543F1, 32'hFFFFFFF1, 1'b1, 1'b1, 5'd1};
        vecs[1]  = '{1'b1, 1'b1, 2'b01, 3'b100, 5'd2,  32'h1003, 32'h876543F1, 32'h00000087, 1'b1, 1'b1, 5'd2};
        vecs[2]  = '{1'b1, 1'b1, 2'b01, 3'b001, 5'd3,  32'h1002, 32'h876543F1, 32'hFFFF8765, 1'b1, 1'b1, 5'd3};
        vecs[3]  = '{1'b1, 1'b1, 2'b01, 3'b101, 5'd4,  32'h1003, 32'h876543F1, 32'h00008765, 1'b1, 1'b1, 5'd4};
        vecs[4]  = '{1'b1, 1'b1, 2'b01, 3'b010, 5'd5,  32'h1000, 32'h876543F1, 32'h876543F1, 1'b1, 1'b1, 5'd5};
        vecs[5]  = '{1'b1, 1'b1, 2'b01, 3'b000, 5'd6,  32'h1001, 32'h876543F1, 32'h00000043, 1'b1, 1'b1, 5'd6};
        vecs[6]  = '{1'b1, 1'b1, 2'b01, 3'b000, 5'd7,  32'h1003, 32'h876543F1, 32'hFFFFFF87, 1'b1, 1'b1, 5'd7};
        vecs[7]  = '{1'b1, 1'b1, 2'b01, 3'b100, 5'd8,  32'h1002, 32'h876543F1, 32'h00000065, 1'b1, 1'b1, 5'd8};
        vecs[8]  = '{1'b1, 1'b1, 2'b01, 3'b001, 5'd9,  32'h1001, 32'h876543F1, 32'h000043F1, 1'b1, 1'b1, 5'd9};
        vecs[9]  = '{1'b1, 1'b1, 2'b01, 3'b011, 5'd10, 32'h1001, 32'h876543F1, 32'h876543F1, 1'b1, 1'b1, 5'd10};
        vecs[10] = '{1'b1, 1'b1, 2'b01, 3'b110, 5'd11, 32'h1002, 32'h876543F1, 32'h876543F1, 1'b1, 1'b1, 5'd11};
        vecs[11] = '{1'b1, 1'b1, 2'b01, 3'b111, 5'd12, 32'h1003, 32'h876543F1, 32'h876543F1, 1'b1, 1'b1, 5'd12};
        vecs[12] = '{1'b1, 1'b1, 2'b00, 3'b000, 5'd5,  32'h10,   32'h876543F1, 32'h00000010, 1'b1, 1'b1, 5'd5};
        vecs[13] = '{1'b1, 1'b1, 2'b10, 3'b000, 5'd5,  32'h10,   32'h876543F1, 32'h00000104, 1'b1, 1'b1, 5'd5};
        vecs[14] = '{1'b1, 1'b1, 2'b11, 3'b000, 5'd5,  32'h10,   32'h876543F1, 32'h12345000, 1'b1, 1'b1, 5'd5};
        vecs[15] = '{1'b1, 1'b1, 2'b00, 3'b000, 5'd0,  32'h10,   32'h876543F1, 32'h00000010, 1'b1, 1'b0, 5'd0};
        vecs[16] = '{1'b0, 1'b1, 2'b00, 3'b000, 5'd3,  32'h20,   32'h876543F1, 32'h00000020, 1'b0, 1'b0, 5'd3};
        vecs[17] = '{1'b1, 1'b0, 2'b00, 3'b000, 5'd5,  32'h30,   32'h876543F1, 32'h00000030, 1'b1, 1'b0, 5'd5};
        vecs[18] = '{1'b1, 1'b1, 2'b11, 3'b000, 5'd31, 32'h40,   32'h876543F1, 32'h12345000, 1'b1, 1'b1, 5'd31};

        rst_n = 1'b0; StallW = 1'b0; FlushW = 1'b0;
        setM(1'b0, 1'b0, 2'b00, 3'b000, 5'd0, 32'h0);
        ReadDataM = 32'h0; PCPlus4M = 32'h104; ImmExtM = 32'h12345000;
        #12;
        checkW("reset", 1'b0, 1'b0, 5'd0, 32'h0);
        checkRetire("reset.RetireCount", 64'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < NVEC; i++) begin
            setM(vecs[i].validM, vecs[i].regWriteM, vecs[i].src, vecs[i].f3, vecs[i].rd, vecs[i].alu);
            ReadDataM = vecs[i].rdata;
            tick();
            checkW($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expWe, vecs[i].expRd, vecs[i].expRes);
        end

        // Stall holds instruction A while M presents B.
        setM(1'b1, 1'b1, 2'b00, 3'b000, 5'd7, 32'hAA);
        tick();
        checkW("stallA.load", 1'b1, 1'b1, 5'd7, 32'hAA);
        setM(1'b1, 1'b1, 2'b00, 3'b000, 5'd9, 32'hBB);
        StallW = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checkW($sformatf("stallA.hold%0d", c), 1'b1, 1'b1, 5'd7, 32'hAA);
        end
        StallW = 1'b0;
        tick();
        checkW("stall.release", 1'b1, 1'b1, 5'd9, 32'hBB);
        StallW = 1'b1; FlushW = 1'b1;
        tick();
        checkW("stallflush", 1'b0, 1'b0, 5'd0, 32'h0);
        StallW = 1'b0; FlushW = 1'b0;
        tick();
        checkW("postflush", 1'b1, 1'b1, 5'd9, 32'hBB);

        // Asynchronous reset during a stall clears outputs before any edge.
        StallW = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkW("midreset", 1'b0, 1'b0, 5'd0, 32'h0);
        checkRetire("midreset.RetireCount", 64'd0);
        @(negedge clk);
        rst_n = 1'b1; StallW = 1'b0;

        // Retire sequence: 10 valid, 2 stalls, 1 bubble; final step flushes with I10 in WB.
        begin
            logic [2:0] steps [15];
            logic [63:0] expCnt [15];
            steps[0]  = 3'b100; expCnt[0]  = 64'd0;
            steps[1]  = 3'b100; expCnt[1]  = 64'd1;
            steps[2]  = 3'b110; expCnt[2]  = 64'd1;
            steps[3]  = 3'b110; expCnt[3]  = 64'd1;
            steps[4]  = 3'b100; expCnt[4]  = 64'd2;
            steps[5]  = 3'b000; expCnt[5]  = 64'd3;
            steps[6]  = 3'b100; expCnt[6]  = 64'd3;
            steps[7]  = 3'b100; expCnt[7]  = 64'd4;
            steps[8]  = 3'b100; expCnt[8]  = 64'd5;
            steps[9]  = 3'b100; expCnt[9]  = 64'd6;
            steps[10] = 3'b100; expCnt[10] = 64'd7;
            steps[11] = 3'b100; expCnt[11] = 64'd8;
            steps[12] = 3'b100; expCnt[12] = 64'd9;
            steps[13] = 3'b001; expCnt[13] = 64'd10;
            steps[14] = 3'b000; expCnt[14] = 64'd10;
            for (int s = 0; s < 15; s++) begin
                setM(steps[s][2], 1'b1, 2'b00, 3'b000, 5'(s + 1), 32'(s));
                StallW = steps[s][1];
                FlushW = steps[s][0];
                tick();
                checkRetire($sformatf("retire.step%0d", s), expCnt[s]);
            end
            StallW = 1'b0; FlushW = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
`default_nettype wire
